frame_pad: RTL and testbench
============================

FRAME_PAD -- requirements
Module: frame_pad

Interface
REQ-001 Parameter WIDTH, default 320, active pixels per input row.
REQ-002 Parameter HEIGHT, default 240, active rows per input frame.
REQ-003 Parameter PAD, default 1, border size in pixels on every side; legal range 1..4.
REQ-004 Parameter CHANNELS, default 3, colour channels packed per pixel.
REQ-005 Parameter DW, default 8, bits per channel.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 newFrame  input  1  one-cycle pulse that starts a frame.
REQ-009 iMode  input  2  border mode, sampled on newFrame: 0 zero, 1 constant, 2 horizontal replicate, 3 treated as 0.
REQ-010 iPadValue  input  CHANNELS*DW  constant border pixel for mode 1, sampled on newFrame.
REQ-011 iValid  input  1  input pixel valid.
REQ-012 iData  input  CHANNELS*DW  input pixel, channel 0 in the MSBs.
REQ-013 iReady  output  1  block accepts iData this cycle; transfer occurs when iValid and iReady are both high.
REQ-014 oValid  output  1  registered output pixel valid.
REQ-015 oData  output  CHANNELS*DW  registered output pixel.
REQ-016 oDone  output  1  one-cycle pulse after the last pixel of a padded frame.

Function
REQ-017 The block SHALL emit exactly (WIDTH+2*PAD)*(HEIGHT+2*PAD) valid pixels per frame, in raster order.
REQ-018 The FSM SHALL have states IDLE, TOP, LEFT, BODY, RIGHT, BOTTOM and DONE.
REQ-019 IDLE: iReady=0 and no output; newFrame moves the FSM to TOP and clears the row and column counters.
REQ-020 TOP: emit PAD rows of WIDTH+2*PAD border pixels, one per cycle with no gaps; iReady=0; then go to LEFT.
REQ-021 Border pixels in TOP and BOTTOM SHALL be iPadValue in mode 1 and zero in all other modes.
REQ-022 LEFT in modes 0/1: emit PAD border pixels, one per cycle, with iReady=0; then go to BODY.
REQ-023 LEFT in mode 2: hold iReady=1 until the first pixel of the row transfers and capture it; then emit PAD copies of it with iReady=0; then go to BODY.
REQ-024 BODY: iReady=1; each transferred pixel appears on oData with oValid one cycle later.
REQ-025 BODY SHALL consume WIDTH pixels in modes 0/1; in mode 2 it SHALL first emit the captured pixel, then consume WIDTH-1 pixels.
REQ-026 iValid gaps in BODY SHALL produce oValid gaps only; the output pixel sequence SHALL not change.
REQ-027 RIGHT: iReady=0; emit PAD border pixels: the last body pixel in mode 2, otherwise as in LEFT.
REQ-028 After RIGHT, go to LEFT if fewer than HEIGHT rows are done, else to BOTTOM.
REQ-029 BOTTOM: emit PAD border rows as in TOP, then go to DONE.
REQ-030 DONE: oDone=1 for one cycle, in the cycle after the last oValid; then go to IDLE.
REQ-031 newFrame in any non-IDLE state SHALL abort the current frame: next state TOP, counters cleared, iMode and iPadValue resampled, no oDone for the aborted frame.
REQ-032 newFrame coincident with DONE SHALL still produce the oDone pulse and then enter TOP.
REQ-033 iValid while iReady=0 SHALL be ignored; the pixel is not consumed.
REQ-034 Output latency SHALL be one cycle from the transfer or FSM decision to oValid/oData.
REQ-035 Row and column counters SHALL be sized by $clog2 of WIDTH+2*PAD and HEIGHT+2*PAD, and SHALL never wrap within a frame.

Reset
REQ-036 When reset is high, the FSM SHALL go to IDLE and clear all counters.
REQ-037 Reset SHALL force oValid=0, oData=0, oDone=0 and iReady=0, and clear the captured pixel and the sampled mode/pad registers.
REQ-038 Reset SHALL override newFrame in the same cycle; reset mid-frame SHALL discard the frame silently.

Verification (WIDTH=4, HEIGHT=3, PAD=1, CHANNELS=1, DW=8)
REQ-039 Mode 0, input 1..12 with iValid held high:
  - 30 output pixels: 0,0,0,0,0,0, 0,1,2,3,4,0, 0,5,6,7,8,0, 0,9,10,11,12,0, 0,0,0,0,0,0;
  - oDone pulses once.
REQ-040 Mode 1 with iPadValue=0xAA, same input: every border pixel is 0xAA and the body is unchanged.
REQ-041 Mode 2, rows 1-4 / 5-8 / 9-12: body rows are 1,1,2,3,4,4 / 5,5,6,7,8,8 / 9,9,10,11,12,12, and the TOP/BOTTOM rows are zero.
REQ-042 Mode 0 with iValid toggling randomly and 16-cycle gaps between rows: the output sequence is identical to REQ-039 and contains 30 oValid pulses.
REQ-043 newFrame asserted after 8 output pixels: output restarts with 6 TOP zeros, no oDone for the aborted frame, and the following complete frame matches REQ-039.
REQ-044 Reset held for 2 cycles mid-BODY: oValid, oDone and iReady are 0 the next cycle, and the FSM stays in IDLE until newFrame.

Source files
------------

// File: rtl/frame_pad_if.sv
// Pixel stream bundle for frame_pad: frame control, input handshake and padded output.
// master drives frames and pixels in; slave is the padder itself.
interface frame_pad_if #(
    parameter int unsigned PW = 24
);
    logic          newFrame;
    logic [1:0]    iMode;
    logic [PW-1:0] iPadValue;
    logic          iValid;
    logic [PW-1:0] iData;
    logic          iReady;
    logic          oValid;
    logic [PW-1:0] oData;
    logic          oDone;

    modport master (
        output newFrame, iMode, iPadValue, iValid, iData,
        input  iReady, oValid, oData, oDone
    );

    modport slave (
        input  newFrame, iMode, iPadValue, iValid, iData,
        output iReady, oValid, oData, oDone
    );
endinterface

// File: rtl/frame_pad.sv
// Adds a PAD-pixel border around a raster frame (zero, constant or horizontal replicate)
// and streams the padded frame out in raster order with one cycle of latency.
module frame_pad #(
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240,
    parameter int unsigned PAD      = 1,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DW       = 8
) (
    input logic        clk,
    input logic        reset,
    frame_pad_if.slave bus
);
    localparam int unsigned PW      = CHANNELS * DW;
    localparam int unsigned RowW    = WIDTH + 2 * PAD;
    localparam int unsigned ColBits = $clog2(WIDTH + 2 * PAD);
    localparam int unsigned RowBits = $clog2(HEIGHT + 2 * PAD);

    localparam logic [ColBits-1:0] ColOne      = ColBits'(1);
    localparam logic [ColBits-1:0] ColRowLast  = ColBits'(RowW - 1);
    localparam logic [ColBits-1:0] ColPadLast  = ColBits'(PAD - 1);
    localparam logic [ColBits-1:0] ColBodyLast = ColBits'(WIDTH - 1);
    localparam logic [RowBits-1:0] RowOne      = RowBits'(1);
    localparam logic [RowBits-1:0] RowPadLast  = RowBits'(PAD - 1);
    localparam logic [RowBits-1:0] RowBodyLast = RowBits'(HEIGHT - 1);

    typedef enum logic [2:0] {
        StIdle, StTop, StLeft, StBody, StRight, StBottom, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [ColBits-1:0] col_q, col_d;
    logic [RowBits-1:0] row_q, row_d;
    logic               cap_done_q, cap_done_d;
    logic [1:0]         mode_q;
    logic [PW-1:0]      pad_q, cap_q, last_q;
    logic               o_valid_q, o_valid_d;
    logic               o_done_q, o_done_d;
    logic [PW-1:0]      o_data_q, o_data_d;
    logic               ready, xfer, cap_en, last_en, rep;
    logic [PW-1:0]      border_px;

    assign rep       = (mode_q == 2'd2);
    assign border_px = (mode_q == 2'd1) ? pad_q : '0;

    // Ready is withheld on a newFrame cycle so an aborted frame never swallows a pixel.
    assign ready = !reset && !bus.newFrame &&
                   (((state_q == StBody) && !(rep && (col_q == '0))) ||
                    ((state_q == StLeft) && rep && !cap_done_q));
    assign xfer       = bus.iValid && ready;
    assign bus.iReady = ready;
    assign bus.oValid = o_valid_q;
    assign bus.oData  = o_data_q;
    assign bus.oDone  = o_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            cap_done_q <= 1'b0;
            mode_q     <= 2'd0;
            pad_q      <= '0;
            cap_q      <= '0;
            last_q     <= '0;
            o_valid_q  <= 1'b0;
            o_done_q   <= 1'b0;
            o_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cap_done_q <= cap_done_d;
            if (bus.newFrame) begin
                mode_q <= bus.iMode;
                pad_q  <= bus.iPadValue;
            end
            if (cap_en) cap_q <= bus.iData;
            if (last_en) last_q <= o_data_d;
            o_valid_q <= o_valid_d;
            o_done_q  <= o_done_d;
            o_data_q  <= o_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cap_done_d = cap_done_q;
        unique case (state_q)
            StTop, StBottom: begin
                if (col_q == ColRowLast) begin
                    col_d = '0;
                    if (row_q == RowPadLast) begin
                        row_d   = '0;
                        state_d = (state_q == StTop) ? StLeft : StDone;
                    end else begin
                        row_d = row_q + RowOne;
                    end
                end else begin
                    col_d = col_q + ColOne;
                end
            end
            StLeft: begin
                if (rep && !cap_done_q) begin
                    if (xfer) cap_done_d = 1'b1;
                end else if (col_q == ColPadLast) begin
                    col_d      = '0;
                    cap_done_d = 1'b0;
                    state_d    = StBody;
                end else begin
                    col_d = col_q + ColOne;
                end
            end
            StBody: begin
                // In replicate mode column 0 is the captured pixel, so no transfer is needed.
                if ((rep && (col_q == '0)) || xfer) begin
                    if (col_q == ColBodyLast) begin
                        col_d   = '0;
                        state_d = StRight;
                    end else begin
                        col_d = col_q + ColOne;
                    end
                end
            end
            StRight: begin
                if (col_q == ColPadLast) begin
                    col_d = '0;
                    if (row_q == RowBodyLast) begin
                        row_d   = '0;
                        state_d = StBottom;
                    end else begin
                        row_d   = row_q + RowOne;
                        state_d = StLeft;
                    end
                end else begin
                    col_d = col_q + ColOne;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.newFrame) begin
            state_d    = StTop;
            col_d      = '0;
            row_d      = '0;
            cap_done_d = 1'b0;
        end
    end

    always_comb begin
        o_valid_d = 1'b0;
        o_data_d  = '0;
        o_done_d  = 1'b0;
        cap_en    = 1'b0;
        last_en   = 1'b0;
        unique case (state_q)
            StTop, StBottom: begin
                o_valid_d = 1'b1;
                o_data_d  = border_px;
            end
            StLeft: begin
                if (rep && !cap_done_q) begin
                    cap_en = xfer;
                end else begin
                    o_valid_d = 1'b1;
                    o_data_d  = rep ? cap_q : border_px;
                end
            end
            StBody: begin
                if (rep && (col_q == '0)) begin
                    o_valid_d = 1'b1;
                    o_data_d  = cap_q;
                    last_en   = 1'b1;
                end else if (xfer) begin
                    o_valid_d = 1'b1;
                    o_data_d  = bus.iData;
                    last_en   = 1'b1;
                end
            end
            StRight: begin
                o_valid_d = 1'b1;
                o_data_d  = rep ? last_q : border_px;
            end
            StDone:  o_done_d = 1'b1;
            default: o_done_d = 1'b0;
        endcase
        // An abort drops whatever the old frame would have emitted this cycle.
        if (bus.newFrame && (state_q != StDone)) begin
            o_valid_d = 1'b0;
            o_data_d  = '0;
            last_en   = 1'b0;
        end
    end
endmodule

// File: tb/tb_frame_pad.sv
// Scoreboard bench for frame_pad at 4x3, PAD=1, one 8-bit channel: directed frames are
// queued as hand-computed pixel lists and a negedge monitor pops and compares them.
module tb_frame_pad;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned P  = 1;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_pad_if #(.PW(PW)) bus ();

    frame_pad #(
        .WIDTH(W), .HEIGHT(H), .PAD(P), .CHANNELS(1), .DW(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] exp0 [30] = '{0, 0, 0, 0, 0, 0,   0, 1, 2, 3, 4, 0,   0, 5, 6, 7, 8, 0,
                              0, 9, 10, 11, 12, 0,   0, 0, 0, 0, 0, 0};
    logic [7:0] exp1 [30] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA,
                              8'hAA, 1, 2, 3, 4, 8'hAA,   8'hAA, 5, 6, 7, 8, 8'hAA,
                              8'hAA, 9, 10, 11, 12, 8'hAA,
                              8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    logic [7:0] exp2 [30] = '{0, 0, 0, 0, 0, 0,   1, 1, 2, 3, 4, 4,   5, 5, 6, 7, 8, 8,
                              9, 9, 10, 11, 12, 12,   0, 0, 0, 0, 0, 0};

    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.oValid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL extra_pixel: got %0d, required no pixel", bus.oData);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.oData !== mon_exp) begin
                    n_err++;
                    $display("FAIL pixel: got %0d, required %0d", bus.oData, mon_exp);
                end
            end
        end
        if (bus.oDone === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (!prev_valid || (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL done_timing: prev_valid %0b pending %0d, required 1 and 0",
                         prev_valid, exp_q.size());
            end
        end
        prev_valid = (bus.oValid === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Entered and left at posedge+1; mode/pad are scrambled afterwards to prove sampling.
    task automatic start_frame(input logic [1:0] mode, input logic [7:0] padv);
        bus.newFrame  = 1'b1;
        bus.iMode     = mode;
        bus.iPadValue = padv;
        @(posedge clk); #1;
        bus.newFrame  = 1'b0;
        bus.iMode     = 2'd3;
        bus.iPadValue = 8'h55;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit gaps);
        logic acc = 1'b0;
        int   guard = 0;
        bus.iData = d;
        while (!acc) begin
            bus.iValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = bus.iValid && bus.iReady;
            @(posedge clk); #1;
            guard++;
            if (!acc && guard > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL handshake_timeout: pixel %0d not taken, required taken", d);
                acc = 1'b1;
            end
        end
        if (gaps) bus.iValid = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] mode, input logic [7:0] padv, input bit gaps,
                              input int npix);
        start_frame(mode, padv);
        for (int i = 1; i <= npix; i++) begin
            send_pixel(8'(i), gaps);
            if (gaps && (i % W == 0)) begin
                bus.iValid = 1'b0;
                repeat (16) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_done(input int want);
        int n = 0;
        while ((done_cnt < want) && (n < 300)) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("done_count", done_cnt, want);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.newFrame  = 1'b0;
        bus.iMode     = 2'd0;
        bus.iPadValue = '0;
        bus.iValid    = 1'b0;
        bus.iData     = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_oValid", bus.oValid, 0);
        check("rst_oDone", bus.oDone, 0);
        check("rst_iReady", bus.iReady, 0);
        check("rst_oData", bus.oData, 0);
        @(posedge clk); #1;

        // Zero border, iValid held high (also offered while iReady is low).
        for (int i = 0; i < 30; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b0, 12);
        wait_done(1);

        // Constant border.
        for (int i = 0; i < 30; i++) exp_q.push_back(exp1[i]);
        send_frame(2'd1, 8'hAA, 1'b0, 12);
        wait_done(2);

        // Horizontal replicate.
        for (int i = 0; i < 30; i++) exp_q.push_back(exp2[i]);
        send_frame(2'd2, 8'h77, 1'b0, 12);
        wait_done(3);

        // Random iValid and 16-cycle row gaps.
        for (int i = 0; i < 30; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b1, 12);
        wait_done(4);

        // Abort after 8 output pixels, then a full frame.
        bus.iValid = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b0, 1);
        for (int i = 0; i < 30; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b0, 12);
        wait_done(5);

        // Reset for two cycles just after the first pixel of body row 2.
        for (int i = 0; i < 14; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b0, 5);
        reset      = 1'b1;
        bus.iValid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_oValid", bus.oValid, 0);
        check("post_rst_oDone", bus.oDone, 0);
        check("post_rst_iReady", bus.iReady, 0);
        check("post_rst_oData", bus.oData, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_iReady", bus.iReady, 0);
            check("idle_oValid", bus.oValid, 0);
        end
        check("rst_queue_drained", exp_q.size(), 0);
        check("rst_no_done", done_cnt, 5);
        @(posedge clk); #1;

        // Recovery frame after reset.
        for (int i = 0; i < 30; i++) exp_q.push_back(exp0[i]);
        send_frame(2'd0, 8'h00, 1'b0, 12);
        wait_done(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
